// File: rtl/hazard_forward_ctrl.sv
// Forwarding and interlock controller for the pipelined KGP-RISC core.
// Selects EX operand sources, detects load-use and multi-cycle-unit hazards, and counts stall cycles.
module hazard_forward_ctrl #(
  parameter int REG_AW      = 5,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int MC_LAT      = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_mc_start,
  input  logic [REG_AW-1:0]      id_ex_rs,
  input  logic [REG_AW-1:0]      id_ex_rt,
  input  logic [REG_AW-1:0]      id_ex_rd,
  input  logic                   id_ex_regwrite,
  input  logic                   id_ex_memread,
  input  logic [REG_AW-1:0]      ex_mem_rd,
  input  logic                   ex_mem_regwrite,
  input  logic [REG_AW-1:0]      mem_wb_rd,
  input  logic                   mem_wb_regwrite,
  output logic [1:0]             forwardA,
  output logic [1:0]             forwardB,
  output logic                   stall,
  output logic                   flush_id_ex,
  output logic                   mc_busy,
  output logic                   mc_done,
  output logic [REG_AW-1:0]      mc_rd,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic {IDLE, BUSY} mc_state_e;

  localparam logic [3:0] MC_RELOAD = 4'(MC_LAT - 1);

  mc_state_e               state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [REG_AW-1:0]       mc_rd_q, mc_rd_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic loadUse, mcStruct, mcRaw, mcWaw, mcBlock, hazard, accept;

  // Register 0 is hard-wired in the regfile, so it never matches when ZERO_REG_EN is set.
  function automatic logic regMatch(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && (!ZERO_REG_EN || (a != '0));
  endfunction

  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (!rst) begin
      if (ex_mem_regwrite && regMatch(ex_mem_rd, id_ex_rs))
        forwardA = 2'b10;
      else if (mem_wb_regwrite && regMatch(mem_wb_rd, id_ex_rs))
        forwardA = 2'b01;
      if (ex_mem_regwrite && regMatch(ex_mem_rd, id_ex_rt))
        forwardB = 2'b10;
      else if (mem_wb_regwrite && regMatch(mem_wb_rd, id_ex_rt))
        forwardB = 2'b01;
    end
  end

  // The mc_done cycle releases interlocks: the result is written through to the regfile.
  assign mc_done  = !rst && (state_q == BUSY) && (cnt_q == 4'd0);
  assign mcBlock  = (state_q == BUSY) && !mc_done;
  assign loadUse  = id_ex_memread && id_ex_regwrite &&
                    (regMatch(id_ex_rd, id_rs) || regMatch(id_ex_rd, id_rt));
  assign mcStruct = id_mc_start && mcBlock;
  assign mcRaw    = mcBlock && (regMatch(mc_rd_q, id_rs) || regMatch(mc_rd_q, id_rt));
  assign mcWaw    = mcBlock && id_regwrite && regMatch(mc_rd_q, id_rd);
  assign hazard   = loadUse || mcStruct || mcRaw || mcWaw;

  assign stall       = !rst && hazard;
  assign flush_id_ex = stall;
  assign accept      = !rst && id_mc_start && !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = MC_RELOAD;
          mc_rd_d = id_rd;
        end
      end
      BUSY: begin
        if (mc_done) begin
          if (accept) begin
            cnt_d   = MC_RELOAD;
            mc_rd_d = id_rd;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mc_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_rd_q     <= mc_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mc_busy     = (state_q == BUSY);
  assign mc_rd       = mc_rd_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with hand-computed expectations
// (REG_AW=5, ZERO_REG_EN=1, MC_LAT=4, STALL_CNT_W=16).
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_regwrite, id_mc_start;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_regwrite, id_ex_memread;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [1:0]  forwardA, forwardB;
  logic        stall, flush_id_ex, mc_busy, mc_done;
  logic [4:0]  mc_rd;
  logic [15:0] stall_count;

  int testCount = 0;
  int failCount = 0;

  hazard_forward_ctrl #(
    .REG_AW(5), .ZERO_REG_EN(1'b1), .MC_LAT(4), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_mc_start(id_mc_start),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .forwardA(forwardA), .forwardB(forwardB),
    .stall(stall), .flush_id_ex(flush_id_ex),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    id_rs = '0; id_rt = '0; id_rd = '0; id_regwrite = 0; id_mc_start = 0;
    id_ex_rs = '0; id_ex_rt = '0; id_ex_rd = '0; id_ex_regwrite = 0; id_ex_memread = 0;
    ex_mem_rd = '0; ex_mem_regwrite = 0; mem_wb_rd = '0; mem_wb_regwrite = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus();
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1; id_ex_rs = 5'd3;
    id_ex_rd = 5'd4; id_ex_memread = 1; id_ex_regwrite = 1; id_rs = 5'd4;
    #2;
    checkOutput("rst_fwdA", 32'(forwardA), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("rst_busy", 32'(mc_busy), 32'd0);
    checkOutput("rst_mcrd", 32'(mc_rd), 32'd0);
    checkOutput("rst_cnt", 32'(stall_count), 32'd0);

    // Forwarding priority
    rst = 1'b0;
    applyStimulus();
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1; mem_wb_rd = 5'd3; mem_wb_regwrite = 1; id_ex_rs = 5'd3;
    #1 checkOutput("fwdA_double", 32'(forwardA), 32'd2);
    ex_mem_regwrite = 0;
    #1 checkOutput("fwdA_memwb", 32'(forwardA), 32'd1);
    id_ex_rt = 5'd3;
    #1 checkOutput("fwdB_memwb", 32'(forwardB), 32'd1);
    id_ex_rt = 5'd4; ex_mem_regwrite = 1; ex_mem_rd = 5'd4;
    #1 checkOutput("fwdB_exmem", 32'(forwardB), 32'd2);
    id_ex_rt = 5'd6;
    #1 checkOutput("fwdB_none", 32'(forwardB), 32'd0);

    // Register 0 never forwards or stalls
    applyStimulus();
    ex_mem_regwrite = 1; mem_wb_regwrite = 1; id_ex_regwrite = 1; id_ex_memread = 1; id_regwrite = 1;
    #1;
    checkOutput("zero_fwdA", 32'(forwardA), 32'd0);
    checkOutput("zero_fwdB", 32'(forwardB), 32'd0);
    checkOutput("zero_stall", 32'(stall), 32'd0);

    // Load-use: one bubble, then MEM/WB forwarding
    applyStimulus();
    id_ex_rd = 5'd5; id_ex_memread = 1; id_ex_regwrite = 1; id_rt = 5'd5;
    #1;
    checkOutput("lu_stall", 32'(stall), 32'd1);
    checkOutput("lu_flush", 32'(flush_id_ex), 32'd1);
    tick();
    applyStimulus();
    id_rt = 5'd5; ex_mem_rd = 5'd5; ex_mem_regwrite = 1;
    #1 checkOutput("lu_bubble_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus();
    id_ex_rt = 5'd5; mem_wb_rd = 5'd5; mem_wb_regwrite = 1;
    #1;
    checkOutput("lu_fwdB", 32'(forwardB), 32'd1);
    checkOutput("lu_count", 32'(stall_count), 32'd1);

    // Clear the counter, then a RAW dependency on a multi-cycle op
    rst = 1'b1;
    applyStimulus();
    tick();
    checkOutput("rst2_cnt", 32'(stall_count), 32'd0);
    rst = 1'b0;
    id_mc_start = 1; id_rd = 5'd7; id_regwrite = 1;
    #1 checkOutput("mc_issue_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus();
    id_rs = 5'd7;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checkOutput($sformatf("raw_stall_c%0d", c), 32'(stall), 32'd1);
      checkOutput($sformatf("raw_done_c%0d", c), 32'(mc_done), 32'd0);
      checkOutput($sformatf("raw_busy_c%0d", c), 32'(mc_busy), 32'd1);
      tick();
    end
    #1;
    checkOutput("raw_done", 32'(mc_done), 32'd1);
    checkOutput("raw_done_stall", 32'(stall), 32'd0);
    checkOutput("raw_mcrd", 32'(mc_rd), 32'd7);
    checkOutput("raw_count", 32'(stall_count), 32'd3);
    tick();
    applyStimulus();
    #1 checkOutput("raw_idle", 32'(mc_busy), 32'd0);

    // Back-to-back issue with structural and WAW interlocks
    id_mc_start = 1; id_rd = 5'd7; id_regwrite = 1;
    tick();
    applyStimulus();
    id_mc_start = 1; id_rd = 5'd9; id_regwrite = 1;
    #1 checkOutput("struct_stall", 32'(stall), 32'd1);
    tick();
    applyStimulus();
    id_rd = 5'd7; id_regwrite = 1;
    #1 checkOutput("waw_stall", 32'(stall), 32'd1);
    tick();
    applyStimulus();
    id_mc_start = 1; id_rd = 5'd9; id_regwrite = 1;
    #1 checkOutput("struct_stall2", 32'(stall), 32'd1);
    tick();
    #1;
    checkOutput("b2b_done", 32'(mc_done), 32'd1);
    checkOutput("b2b_stall", 32'(stall), 32'd0);
    checkOutput("b2b_count", 32'(stall_count), 32'd6);
    tick();
    applyStimulus();
    #1;
    checkOutput("b2b_busy", 32'(mc_busy), 32'd1);
    checkOutput("b2b_mcrd", 32'(mc_rd), 32'd9);
    checkOutput("b2b_nodone", 32'(mc_done), 32'd0);

    // Reset while busy aborts the op
    id_rs = 5'd9;
    #1 checkOutput("b2b_raw", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstb_stall", 32'(stall), 32'd0);
    checkOutput("rstb_flush", 32'(flush_id_ex), 32'd0);
    tick();
    checkOutput("rstb_busy", 32'(mc_busy), 32'd0);
    checkOutput("rstb_mcrd", 32'(mc_rd), 32'd0);
    checkOutput("rstb_cnt", 32'(stall_count), 32'd0);
    rst = 1'b0;
    applyStimulus();
    for (int c = 0; c < 5; c++) begin
      #1 checkOutput($sformatf("rstb_nodone_c%0d", c), 32'(mc_done), 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
